demux_1x8_deser: RTL

- Receive-side partner of the 8:1 select mux.
- The transmit side walks select 0..7 over an 8-bit word and emits one bit per step. This block takes that serial stream and routes each bit to output position `sel`, building the word back up.
- It outputs the reassembled 8-bit word with a one-cycle valid pulse.
- It sits directly after the serializing mux in the datapath. It tracks its own select index and recovers from stalled partial frames.

---
 rtl/demux_1x8_deser.sv | 122 ++++++++++++
 1 files changed

// File: rtl/demux_1x8_deser.sv
// demux_1x8_deser: 1:8 serial-to-parallel deserializer with idle timeout and frame_start resync.
// Build with DEMUX_PARITY_EN to expect a trailing even-parity bit after each 8-bit word.
module demux_1x8_deser #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       din_valid,
   input  logic       frame_start,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic [2:0] sel,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
`ifdef DEMUX_PARITY_EN
   localparam logic [1:0] PARITY  = 2'd2;
   logic parity_err_q, parity_err_d;
`endif
   logic [1:0]       state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       shadow_q, shadow_d, word;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             expire;
   always_comb begin
      word         = shadow_q;
      word[sel_q]  = din;
      // expiry fires on the TIMEOUT-th consecutive idle cycle of a partial frame
      expire       = state_q != IDLE && !din_valid && cnt_q == CNT_W'(TIMEOUT - 1);
      state_d      = state_q;
      sel_d        = sel_q;
      shadow_d     = shadow_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      frame_err_d  = state_q != IDLE && (frame_start || expire);
`ifdef DEMUX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (frame_start) begin
         shadow_d = {7'd0, din_valid & din};
         sel_d    = {2'd0, din_valid};
         state_d  = din_valid ? COLLECT : IDLE;
         cnt_d    = '0;
      end else if (expire) begin
         shadow_d = '0;
         sel_d    = '0;
         state_d  = IDLE;
         cnt_d    = '0;
      end else if (din_valid) begin
         cnt_d = '0;
`ifdef DEMUX_PARITY_EN
         if (state_q == PARITY) begin
            dout_d       = shadow_q;
            dout_valid_d = 1'b1;
            parity_err_d = ^shadow_q ^ din;
            shadow_d     = '0;
            state_d      = IDLE;
         end else if (sel_q == 3'd7) begin
            shadow_d = word;
            sel_d    = '0;
            state_d  = PARITY;
         end else begin
`else
         if (sel_q == 3'd7) begin
            dout_d       = word;
            dout_valid_d = 1'b1;
            shadow_d     = '0;
            sel_d        = '0;
            state_d      = IDLE;
         end else begin
`endif
            shadow_d = word;
            sel_d    = sel_q + 3'd1;
            state_d  = COLLECT;
         end
      end else if (state_q != IDLE) begin
         cnt_d = cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         shadow_q     <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         shadow_q     <= shadow_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end
`ifdef DEMUX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= parity_err_d;
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sel        = sel_q;
   assign busy       = state_q != IDLE;
   assign frame_err  = frame_err_q;
endmodule
